// File: rtl/segdisp_scan.sv
// segdisp_scan: multiplexed common-anode seven-segment scan driver.
// Ports: HCLK/HRESETn, disp_data {strobe,hex}, seg/an active-low, digit_count.
module segdisp_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  input  logic [4:0]                        disp_data,
  output logic [7:0]                        seg,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count
);

  localparam int DCW  = $clog2(NUM_DIGITS + 1);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (SCAN_DIV > BLANK_CYCLES) ?
                        SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [DCW-1:0] DC_MAX    = DCW'(NUM_DIGITS);

  typedef enum logic {SHOW, BLANK} state_e;

  state_e state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d, idx_nxt;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DCW-1:0] dc_q, dc_d;
  logic [NUM_DIGITS-1:0]      vld_q, vld_d;
  logic [NUM_DIGITS-1:0][3:0] val_q, val_d;

  logic       lit_vld;
  logic [3:0] lit_val;

  function automatic logic [7:0] decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Right-entry shift buffer; oldest digit drops off the left end.
  always_comb begin
    vld_d = vld_q;
    val_d = val_q;
    dc_d  = dc_q;
    if (disp_data[4]) begin
      vld_d = {vld_q[NUM_DIGITS-2:0], 1'b1};
      val_d = {val_q[NUM_DIGITS-2:0], disp_data[3:0]};
      if (dc_q != DC_MAX)
        dc_d = dc_q + 1'b1;
    end
  end

  // Scan sequencer, free-running and independent of strobes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    unique case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0)
            idx_d = idx_nxt;
          else
            state_d = BLANK;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          idx_d   = idx_nxt;
        end
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    lit_vld = 1'b0;
    lit_val = 4'h0;
    an      = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        lit_vld = vld_q[i];
        lit_val = val_q[i];
        an[i]   = (state_q != SHOW);
      end
    end
    seg = 8'hFF;
    if (state_q == SHOW && lit_vld)
      seg = decode(lit_val);
  end

  assign digit_count = dc_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= SHOW;
      idx_q   <= '0;
      cnt_q   <= '0;
      dc_q    <= '0;
      vld_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dc_q    <= dc_d;
      vld_q   <= vld_d;
      val_q   <= val_d;
    end
  end

endmodule

// File: tb/tb_segdisp_scan.sv
// tb_segdisp_scan: scoreboard bench for segdisp_scan.
// Two instances: BLANK_CYCLES=1 (main) and BLANK_CYCLES=0 (scan only).
module tb_segdisp_scan;

  logic       HCLK;
  logic       HRESETn;
  logic [4:0] disp_data;
  logic [4:0] disp_data1;
  logic [7:0] seg, seg1;
  logic [3:0] an, an1;
  logic [2:0] dc, dc1;

  segdisp_scan #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1)
  ) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .disp_data(disp_data),
    .seg(seg), .an(an), .digit_count(dc)
  );

  segdisp_scan #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(0)
  ) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .disp_data(disp_data1),
    .seg(seg1), .an(an1), .digit_count(dc1)
  );

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [7:0] seg;
    logic [2:0] dc;
    logic [3:0] an1;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int t;
  string cur_tag;
  logic [7:0] e_seg [4];
  int e_dc;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Edges since reset release; defines the expected scan phase.
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) t <= 0;
    else t <= t + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got %h want %h", nm, t, act, exp);
    end
  endtask

  // Monitor: consumes expectations queued for this sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".an"}, 32'(an), 32'(e.an));
        chk({e.tag, ".seg"}, 32'(seg), 32'(e.seg));
        chk({e.tag, ".dc"}, 32'(dc), 32'(e.dc));
        chk({e.tag, ".an_b0"}, 32'(an1), 32'(e.an1));
      end
    end
  end

  task automatic step(input logic [4:0] dd, input logic [7:0] nseg);
    exp_t e;
    int pos, d, pos1;
    logic [3:0] one;
    @(negedge HCLK);
    pos = t % 20;
    d = pos / 5;
    one = 4'b0001 << d;
    e.tag = cur_tag;
    e.an  = (pos % 5 < 4) ? ~one : 4'hF;
    e.seg = (pos % 5 < 4) ? e_seg[d] : 8'hFF;
    e.dc  = 3'(e_dc);
    pos1 = t % 16;
    one = 4'b0001 << (pos1 / 4);
    e.an1 = ~one;
    q.push_back(e);
    disp_data = dd;
    if (dd[4]) begin
      e_seg[3] = e_seg[2];
      e_seg[2] = e_seg[1];
      e_seg[1] = e_seg[0];
      e_seg[0] = nseg;
      if (e_dc < 4) e_dc++;
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 4; i++) e_seg[i] = 8'hFF;
    e_dc = 0;
  endtask

  initial begin
    HRESETn = 1'b0;
    disp_data = 5'h00;
    disp_data1 = 5'h00;
    clear_exp();

    cur_tag = "reset";
    repeat (3) step(5'h00, 8'hFF);
    @(negedge HCLK);
    HRESETn = 1'b1;

    cur_tag = "scan";
    repeat (20) step(5'h00, 8'hFF);

    cur_tag = "single";
    step(5'h13, 8'hB0);
    repeat (20) step(5'h00, 8'hFF);

    cur_tag = "shift";
    step(5'h11, 8'hF9);
    step(5'h12, 8'hA4);
    step(5'h13, 8'hB0);
    step(5'h14, 8'h99);
    step(5'h15, 8'h92);
    repeat (20) step(5'h00, 8'hFF);

    cur_tag = "ignored";
    repeat (10) step(5'h0F, 8'hFF);

    cur_tag = "blank_strobe";
    while (((t + 1) % 5) != 4) step(5'h00, 8'hFF);
    step(5'h17, 8'hF8);
    repeat (5) step(5'h00, 8'hFF);

    cur_tag = "lit_strobe";
    while (((t + 1) % 20) != 1) step(5'h00, 8'hFF);
    step(5'h1A, 8'h88);
    repeat (20) step(5'h00, 8'hFF);

    cur_tag = "midreset";
    while (((t + 1) % 20) != 11) step(5'h00, 8'hFF);
    @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midreset.an", 32'(an), 32'h0000_000E);
    chk("midreset.seg", 32'(seg), 32'h0000_00FF);
    chk("midreset.dc", 32'(dc), 32'h0000_0000);
    chk("midreset.an_b0", 32'(an1), 32'h0000_000E);
    clear_exp();
    repeat (2) step(5'h00, 8'hFF);
    @(negedge HCLK);
    HRESETn = 1'b1;

    cur_tag = "blank0";
    repeat (33) step(5'h00, 8'hFF);

    @(negedge HCLK);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/segdisp_scan.md
# segdisp_scan

Multiplexed seven-segment scan driver that consumes the one-cycle `disp_data` strobes produced by the AHB-lite segment-display peripheral. Each strobe shifts one hex digit into a right-entry digit buffer. The block continuously time-multiplexes that buffer onto a common-anode, active-low multi-digit display, with a blanking gap between digits to suppress ghosting. It sits between the AHB peripheral and the board display pins.

## Interface
- `NUM_DIGITS`, default 4: number of display digits (2–8).
- `SCAN_DIV`, default 50000: HCLK cycles each digit is lit (≥1).
- `BLANK_CYCLES`, default 16: HCLK cycles all digits are off between digits (0 = no blank phase).
- `HCLK`  input  1: clock, rising edge.
- `HRESETn`  input  1: reset, asynchronous, active-low.
- `disp_data`  input  5: bit 4 is the strobe; bits [3:0] are the hex digit value. Bits [3:0] are ignored when bit 4 = 0.
- `seg`  output  8: active-low segments; seg[0]=a … seg[6]=g; seg[7]=dp, held 1.
- `an`  output  NUM_DIGITS: active-low digit enables; an[0] is the rightmost digit.
- `digit_count`  output  $clog2(NUM_DIGITS+1): number of valid digits, saturating at NUM_DIGITS.

## Operation
- **Buffer:** NUM_DIGITS entries of {valid, value[3:0]}. Reset: all valid=0, value=0.
- **Strobe shift:** a strobe is sampled with disp_data[4]=1 on a rising edge.
  - Each strobe shifts buf[i] <= buf[i-1] for i≥1, and loads buf[0] <= {1, disp_data[3:0]}.
  - The oldest digit falls off buf[NUM_DIGITS-1].
  - Strobes on consecutive cycles each shift; none are dropped.
- **digit_count:** increments on each strobe while below NUM_DIGITS, then holds at NUM_DIGITS.
- **Scan FSM:** registers `state` (SHOW, BLANK), `idx` (0..NUM_DIGITS-1) and `cnt`.
  - SHOW: an = ~(1<<idx). seg = decode(buf[idx].value) if buf[idx].valid, else 8'hFF.
  - SHOW → BLANK when cnt == SCAN_DIV-1, with cnt cleared. If BLANK_CYCLES=0, go directly to SHOW with idx advanced.
  - BLANK: an = all 1, seg = 8'hFF.
  - BLANK → SHOW when cnt == BLANK_CYCLES-1, with cnt cleared and idx advanced.
  - idx advances as (idx+1), wrapping from NUM_DIGITS-1 to 0.
- **Decode** (active-low, dp=1), digit → seg:
  - 0–7: C0, F9, A4, B0, 99, 92, 82, F8.
  - 8–F: 80, 90, 88, 83, C6, A1, 86, 8E.
- Buffer shifts and scanning are independent. A strobe never resets or stalls the scan.
- seg/an are combinational decodes of registered state only. There is no combinational path from disp_data to seg/an.

## Timing
- **Reset values:** state=SHOW, idx=0, cnt=0, an = ~1 (e.g. 4'b1110), seg=8'hFF, digit_count=0.
- **Strobe latency:** a strobe sampled at edge k updates buf and digit_count at edge k. seg reflects the new value after edge k if the affected digit is lit.
- **Scan period:** NUM_DIGITS × (SCAN_DIV + BLANK_CYCLES) cycles.
  - Each digit is lit for exactly SCAN_DIV consecutive cycles.
  - With BLANK_CYCLES≥1, at most one an bit is low in any cycle, and never two consecutive digits without a blank.
- **Strobe during BLANK:** the buffer updates and the scan timing is unaffected.
- **Reset mid-operation:** HRESETn low asynchronously forces all reset values. After HRESETn rises, scanning restarts at idx=0 with cnt=0 on the first edge.
- **Counter widths:** cnt is wide enough for max(SCAN_DIV, BLANK_CYCLES)-1. No wrap occurs other than the defined terminal compares.

## Test plan
Use NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1 unless noted.
1. **Reset:** hold HRESETn=0 → an=4'b1110, seg=8'hFF, digit_count=0. After release, an sequence is 1110×4, 1111×1, 1101×4, 1111×1, …, wrapping back to 1110 after 20 cycles.
2. **Single strobe:** disp_data=5'h13 for one cycle → digit_count=1. While an[0] is low, seg=8'hB0; other digits show 8'hFF.
3. **Shift and overflow:** strobes 5'h11, 5'h12, 5'h13, 5'h14, 5'h15 on consecutive cycles → digit_count=4; digits 3..0 show 2, 3, 4, 5 (seg A4, B0, 99, 92); digit 1 is lost.
4. **Ignored data:** disp_data=5'h0F (bit4=0) for 10 cycles → buffer and digit_count unchanged.
5. **Mid-scan updates:** a strobe during BLANK, and another while an[0] is lit (value 5'h1A) → seg changes to 8'h88 the cycle after the edge; scan an sequence timing is unchanged.
6. **Mid-operation reset and BLANK_CYCLES=0:** async reset mid-SHOW at idx=2 → outputs return to reset values immediately. Then with BLANK_CYCLES=0, check an never reads all-ones and the period is 16 cycles.
